// File: rtl/bresenham_raycast.sv
// bresenham_raycast -- grid ray-caster on the occupancy map read port.
//
// Walks the Bresenham line from (start_x,start_y) to (end_x,end_y), reading
// one map cell per step, and stops at the first occupied cell or at the end
// cell. The result (last evaluated cell, hit flag, cell count) is held from
// DONE until the next SETUP.
//
// Optional feature macro: BRESENHAM_RAYCAST_SKIP_ORIGIN_EN
//   defined   -> the start cell is not read; SETUP takes the first step itself,
//                and a zero-length ray finishes without any read.
//   undefined -> the start cell is the first cell read.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-low reset
//   start                one-cycle request, sampled only in IDLE
//   start_x/y, end_x/y   ray origin and end cell (latched on accepted start)
//   x_index, y_index     map read address, held while read_enable is low
//   read_enable          map read strobe, one cycle per cell
//   cell_occupied        map read data, valid READ_LATENCY cycles after strobe
//   hit_x, hit_y         last cell evaluated
//   hit                  walk stopped on an occupied cell
//   cell_count           number of cells evaluated
//   done                 one-cycle completion pulse
//   busy                 high from SETUP through the done cycle
//   fsm_state            current FSM state (debug visibility)
//
// Handshake: start is a single-cycle request accepted only while busy=0;
// the walk is complete when done pulses. There is no back-pressure on the
// map read port: data is expected exactly READ_LATENCY cycles after each
// read_enable.

package ram_pkg;
  parameter int INDEX_W = 8;
  typedef logic [INDEX_W-1:0] index_t;
endpackage

module bresenham_raycast
  import ram_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  index_t           start_x,
  input  index_t           start_y,
  input  index_t           end_x,
  input  index_t           end_y,
  output index_t           x_index,
  output index_t           y_index,
  output logic             read_enable,
  input  logic             cell_occupied,
  output index_t           hit_x,
  output index_t           hit_y,
  output logic             hit,
  output logic [INDEX_W:0] cell_count,
  output logic             done,
  output logic             busy,
  output logic [2:0]       fsm_state
);

  localparam int SW = INDEX_W + 2;
  // Last WAIT count before EVAL; unreachable (and unused) when READ_LATENCY=1.
  localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_READ  = 3'd2,
    S_WAIT  = 3'd3,
    S_EVAL  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state, next_state;

  index_t                cur_x, cur_y, end_x_q, end_y_q, addr_x_q, addr_y_q;
  logic signed [SW-1:0]  dx_q, dy_q, err_q;
  logic                  sx_neg_q, sy_neg_q;
  logic [1:0]            wait_cnt;

  // Setup values derived from the latched coordinates (used in SETUP only).
  index_t                adx, ady;
  logic signed [SW-1:0]  dx_s, dy_s;
  logic                  sx_neg_s, sy_neg_s;

  // One Bresenham step, shared by SETUP (origin skip) and EVAL.
  logic signed [SW-1:0]  op_dx, op_dy, op_err, nerr;
  logic                  op_sx_neg, op_sy_neg;
  logic signed [SW:0]    e2, dx_e, dy_e;
  logic                  step_x, step_y, at_end;
  index_t                nx, ny;

  always_comb begin
    adx      = (end_x_q > cur_x) ? end_x_q - cur_x : cur_x - end_x_q;
    ady      = (end_y_q > cur_y) ? end_y_q - cur_y : cur_y - end_y_q;
    dx_s     = $signed({2'b00, adx});
    dy_s     = -$signed({2'b00, ady});
    sx_neg_s = !(end_x_q > cur_x);
    sy_neg_s = !(end_y_q > cur_y);

    if (state == S_SETUP) begin
      op_dx     = dx_s;
      op_dy     = dy_s;
      op_err    = dx_s + dy_s;
      op_sx_neg = sx_neg_s;
      op_sy_neg = sy_neg_s;
    end else begin
      op_dx     = dx_q;
      op_dy     = dy_q;
      op_err    = err_q;
      op_sx_neg = sx_neg_q;
      op_sy_neg = sy_neg_q;
    end

    e2     = {op_err, 1'b0};
    dx_e   = {op_dx[SW-1], op_dx};
    dy_e   = {op_dy[SW-1], op_dy};
    step_x = (e2 >= dy_e);
    step_y = (e2 <= dx_e);
    nerr   = op_err + (step_x ? op_dy : '0) + (step_y ? op_dx : '0);
    nx     = step_x ? (op_sx_neg ? cur_x - 1'b1 : cur_x + 1'b1) : cur_x;
    ny     = step_y ? (op_sy_neg ? cur_y - 1'b1 : cur_y + 1'b1) : cur_y;
    at_end = (cur_x == end_x_q) && (cur_y == end_y_q);
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_SETUP;
`ifdef BRESENHAM_RAYCAST_SKIP_ORIGIN_EN
      S_SETUP: next_state = at_end ? S_DONE : S_READ;
`else
      S_SETUP: next_state = S_READ;
`endif
      S_READ:  next_state = (READ_LATENCY == 1) ? S_EVAL : S_WAIT;
      S_WAIT:  if (wait_cnt == WAIT_LAST) next_state = S_EVAL;
      S_EVAL:  next_state = (cell_occupied || at_end) ? S_DONE : S_READ;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Walk datapath and held results
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_x      <= '0;
      cur_y      <= '0;
      end_x_q    <= '0;
      end_y_q    <= '0;
      addr_x_q   <= '0;
      addr_y_q   <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      err_q      <= '0;
      sx_neg_q   <= 1'b0;
      sy_neg_q   <= 1'b0;
      wait_cnt   <= '0;
      hit_x      <= '0;
      hit_y      <= '0;
      hit        <= 1'b0;
      cell_count <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cur_x   <= start_x;
          cur_y   <= start_y;
          end_x_q <= end_x;
          end_y_q <= end_y;
        end
        S_SETUP: begin
          dx_q       <= dx_s;
          dy_q       <= dy_s;
          sx_neg_q   <= sx_neg_s;
          sy_neg_q   <= sy_neg_s;
          cell_count <= '0;
          hit        <= 1'b0;
`ifdef BRESENHAM_RAYCAST_SKIP_ORIGIN_EN
          // A zero-length ray reports the start cell without reading it.
          hit_x <= cur_x;
          hit_y <= cur_y;
          if (at_end) begin
            err_q <= dx_s + dy_s;
          end else begin
            err_q <= nerr;
            cur_x <= nx;
            cur_y <= ny;
          end
`else
          err_q <= dx_s + dy_s;
`endif
        end
        S_READ: begin
          addr_x_q <= cur_x;
          addr_y_q <= cur_y;
          wait_cnt <= '0;
        end
        S_WAIT: wait_cnt <= wait_cnt + 1'b1;
        S_EVAL: begin
          cell_count <= cell_count + 1'b1;
          hit_x      <= cur_x;
          hit_y      <= cur_y;
          if (cell_occupied) begin
            hit <= 1'b1;
          end else if (!at_end) begin
            err_q <= nerr;
            cur_x <= nx;
            cur_y <= ny;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    read_enable = (state == S_READ);
    // The address is live during the strobe and held afterwards.
    x_index     = read_enable ? cur_x : addr_x_q;
    y_index     = read_enable ? cur_y : addr_y_q;
    done        = (state == S_DONE);
    busy        = (state != S_IDLE);
    fsm_state   = state;
  end

endmodule

// File: tb/tb_bresenham_raycast.sv
// Testbench for bresenham_raycast: one instance with READ_LATENCY=1 and one
// with READ_LATENCY=3 share the request inputs; a select picks which one is
// started and observed. A map model answers reads with the configured
// latency, and a Bresenham reference model predicts reads, timing and result.
module tb_bresenham_raycast;
  import ram_pkg::*;

  logic   clock, reset, start, sel;
  index_t in_sx, in_sy, in_ex, in_ey;

  index_t a_x, a_y, a_hx, a_hy, b_x, b_y, b_hx, b_hy;
  logic   a_re, a_occ, a_hit, a_done, a_busy, b_re, b_occ, b_hit, b_done, b_busy;
  logic [INDEX_W:0] a_cnt, b_cnt;
  logic [2:0] a_state, b_state;
  logic   a_start, b_start;

  index_t m_x, m_y, m_hx, m_hy;
  logic   m_re, m_hit, m_done, m_busy;
  logic [INDEX_W:0] m_cnt;

  logic   occ_map [0:255][0:255];
  logic [3:0] a_pipe, b_pipe;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model results
  int exp_x[$];
  int exp_y[$];
  bit exp_hit;
  int exp_hx, exp_hy;

  assign a_start = start && !sel;
  assign b_start = start && sel;

  bresenham_raycast #(.READ_LATENCY(1)) u_a (
    .clock(clock), .reset(reset), .start(a_start),
    .start_x(in_sx), .start_y(in_sy), .end_x(in_ex), .end_y(in_ey),
    .x_index(a_x), .y_index(a_y), .read_enable(a_re), .cell_occupied(a_occ),
    .hit_x(a_hx), .hit_y(a_hy), .hit(a_hit), .cell_count(a_cnt),
    .done(a_done), .busy(a_busy), .fsm_state(a_state)
  );

  bresenham_raycast #(.READ_LATENCY(3)) u_b (
    .clock(clock), .reset(reset), .start(b_start),
    .start_x(in_sx), .start_y(in_sy), .end_x(in_ex), .end_y(in_ey),
    .x_index(b_x), .y_index(b_y), .read_enable(b_re), .cell_occupied(b_occ),
    .hit_x(b_hx), .hit_y(b_hy), .hit(b_hit), .cell_count(b_cnt),
    .done(b_done), .busy(b_busy), .fsm_state(b_state)
  );

  always_comb begin
    if (sel) begin
      m_x = b_x; m_y = b_y; m_hx = b_hx; m_hy = b_hy; m_re = b_re;
      m_hit = b_hit; m_done = b_done; m_busy = b_busy; m_cnt = b_cnt;
    end else begin
      m_x = a_x; m_y = a_y; m_hx = a_hx; m_hy = a_hy; m_re = a_re;
      m_hit = a_hit; m_done = a_done; m_busy = a_busy; m_cnt = a_cnt;
    end
  end

  // Map model: data for a read appears 1 (instance a) or 3 (instance b) cycles later.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_pipe <= '0;
      b_pipe <= '0;
    end else begin
      a_pipe <= {a_pipe[2:0], a_re ? occ_map[a_x][a_y] : 1'b0};
      b_pipe <= {b_pipe[2:0], b_re ? occ_map[b_x][b_y] : 1'b0};
    end
  end
  assign a_occ = a_pipe[0];
  assign b_occ = b_pipe[2];

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_map();
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 256; j++)
        occ_map[i][j] = 1'b0;
  endtask

  task automatic random_map(input int pct);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        occ_map[i][j] = ($urandom_range(99) < pct);
  endtask

  // Line cells from the stepping rule, then truncated at the first occupied cell.
  function automatic void model(input int x0, input int y0, input int x1, input int y1);
    int lx[$];
    int ly[$];
    int x, y, dx, dy, sx, sy, err, e2;
    exp_x.delete();
    exp_y.delete();
    x = x0; y = y0;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y0 - y1 : y1 - y0;
    sx = (x1 > x0) ? 1 : -1;
    sy = (y1 > y0) ? 1 : -1;
    err = dx + dy;
    forever begin
      lx.push_back(x);
      ly.push_back(y);
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
`ifdef BRESENHAM_RAYCAST_SKIP_ORIGIN_EN
    void'(lx.pop_front());
    void'(ly.pop_front());
`endif
    exp_hit = 1'b0;
    exp_hx  = x0;
    exp_hy  = y0;
    for (int i = 0; i < lx.size(); i++) begin
      exp_x.push_back(lx[i]);
      exp_y.push_back(ly[i]);
      exp_hx = lx[i];
      exp_hy = ly[i];
      if (occ_map[lx[i]][ly[i]]) begin
        exp_hit = 1'b1;
        break;
      end
    end
  endfunction

  // Run one ray on the selected instance; spur >= 0 pulses start (with other
  // coordinates) at that cycle, which must be ignored.
  task automatic run_ray(input bit use_b, input int x0, input int y0,
                         input int x1, input int y1, input int spur);
    int lat, k, done_exp, cyc, rd, done_cyc, busy_bad;
    lat = use_b ? 3 : 1;
    model(x0, y0, x1, y1);
    k = exp_x.size();
    done_exp = 2 + k * (lat + 1);
    @(negedge clock);
    sel = use_b;
    in_sx = index_t'(x0); in_sy = index_t'(y0);
    in_ex = index_t'(x1); in_ey = index_t'(y1);
    start = 1'b1;
    cyc = 0; rd = 0; done_cyc = -1; busy_bad = 0;
    check("idle_busy", m_busy, 0);
    while (done_cyc < 0 && cyc < 400) begin
      @(negedge clock);
      cyc++;
      start = (cyc == spur);
      in_sx = index_t'($urandom_range(15)); in_sy = index_t'($urandom_range(15));
      in_ex = index_t'($urandom_range(15)); in_ey = index_t'($urandom_range(15));
      if (!m_busy) busy_bad++;
      if (m_re) begin
        if (rd < k) begin
          check("rd_x", m_x, exp_x[rd]);
          check("rd_y", m_y, exp_y[rd]);
          check("rd_cyc", cyc, 2 + rd * (lat + 1));
        end
        rd++;
      end
      if (m_done) done_cyc = cyc;
    end
    start = 1'b0;
    check("done_cyc", done_cyc, done_exp);
    check("reads", rd, k);
    check("busy_gap", busy_bad, 0);
    check("hit", m_hit, exp_hit);
    check("hit_x", m_hx, exp_hx);
    check("hit_y", m_hy, exp_hy);
    check("cell_count", m_cnt, k);
    @(negedge clock);
    check("done_width", m_done, 0);
    check("busy_after", m_busy, 0);
    check("count_hold", m_cnt, k);
    repeat ($urandom_range(2)) @(negedge clock);
  endtask

  // Asynchronous reset in the middle of a walk on instance a.
  task automatic reset_mid();
    int cyc, done_seen;
    clear_map();
    @(negedge clock);
    sel = 1'b0;
    in_sx = 2; in_sy = 5; in_ex = 6; in_ey = 5;
    start = 1'b1;
    for (cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clock);
      start = 1'b0;
    end
    check("pre_reset_busy", m_busy, 1);
    reset = 1'b0;
    #1;
    check("rst_busy", m_busy, 0);
    check("rst_re", m_re, 0);
    check("rst_done", m_done, 0);
    check("rst_hit", m_hit, 0);
    check("rst_cnt", m_cnt, 0);
    check("rst_hxy", {m_hx, m_hy}, 0);
    check("rst_addr", {m_x, m_y}, 0);
    done_seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (m_done || m_busy) done_seen++;
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clock);
      if (m_done || m_busy) done_seen++;
    end
    check("rst_no_done", done_seen, 0);
    run_ray(1'b0, 2, 5, 6, 5, -1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; sel = 1'b0;
    in_sx = '0; in_sy = '0; in_ex = '0; in_ey = '0;
    clear_map();
    repeat (3) @(negedge clock);
    check("reset_busy", m_busy, 0);
    check("reset_cnt", m_cnt, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Directed rays
    run_ray(1'b0, 2, 5, 6, 5, -1);
    occ_map[4][5] = 1'b1;
    run_ray(1'b0, 2, 5, 6, 5, -1);
    clear_map();
    run_ray(1'b0, 0, 0, 3, 2, -1);
    run_ray(1'b0, 5, 5, 5, 2, -1);
    run_ray(1'b1, 0, 0, 1, 0, 4);
    run_ray(1'b0, 3, 3, 3, 3, -1);
    run_ray(1'b1, 3, 3, 3, 3, -1);
    reset_mid();

    // Randomized rays on both latencies
    for (int n = 0; n < 60; n++) begin
      if (n % 5 == 0) random_map($urandom_range(20));
      run_ray($urandom_range(1), $urandom_range(15), $urandom_range(15),
              $urandom_range(15), $urandom_range(15), $urandom_range(1, 20));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bresenham_raycast.md
# bresenham_raycast

Grid ray-caster: given a start cell and an end cell, walks the Bresenham line between them, reading each cell from the occupancy map RAM. It stops at the first occupied cell or at the end cell. It is the read-side counterpart of the ray-tracing map writer: it sits between the scan-matching logic and the map RAM read port and produces expected-hit cells for simulated scans.

## Interface
Parameters:
- READ_LATENCY, 1, cycles from `read_enable` to valid `cell_occupied`; legal values are 1 to 4.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- start_x, start_y  in  ram_pkg::index_t  ray origin cell
- end_x, end_y  in  ram_pkg::index_t  ray end cell
- x_index, y_index  out  ram_pkg::index_t  map read address
- read_enable  out  1  map read strobe, one cycle per cell
- cell_occupied  in  1  map read data, valid READ_LATENCY cycles after `read_enable`
- hit_x, hit_y  out  ram_pkg::index_t  last cell evaluated
- hit  out  1  1 if the walk stopped on an occupied cell
- cell_count  out  index_t width + 1  number of cells read
- done  out  1  one-cycle completion pulse
- busy  out  1  high from the cycle after accepted `start` through the `done` cycle

## Operation
- FSM states are IDLE, SETUP, READ, WAIT, EVAL, DONE.
- IDLE:
  - On `start`=1, latch all four coordinates and go to SETUP.
  - `start` is ignored in all other states.
- SETUP:
  - dx=|end_x-start_x|, dy=-|end_y-start_y|.
  - sx=+1 if end_x>start_x, else -1; sy likewise from the y coordinates.
  - err=dx+dy.
  - Clear `cell_count` and `hit`.
  - Go to READ, or apply the origin-skip rule (see Configuration).
- READ:
  - Drive `x_index`/`y_index` with the current cell and assert `read_enable` for this cycle only.
  - If READ_LATENCY=1, go to EVAL; otherwise go to WAIT.
- WAIT: count READ_LATENCY-1 cycles, then go to EVAL.
- EVAL (`cell_occupied` is valid in this cycle):
  - cell_count += 1; hit_x/hit_y <= current cell.
  - If `cell_occupied`=1: hit<=1, go to DONE.
  - Else if current cell equals the end cell: go to DONE.
  - Else step the cell and go to READ. Step: e2=2·err; if e2>=dy, err+=dy and x+=sx; if e2<=dx, err+=dx and y+=sy.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Arithmetic:
  - `err`, `dx`, `dy` are signed, index_t width + 2 bits.
  - Coordinates never leave the start/end bounding box, so there is no wrap-around.
- `x_index`/`y_index` hold their last value when `read_enable`=0.
- Outputs `hit`, `hit_x`, `hit_y`, `cell_count` hold from DONE until the next SETUP.
- Reset is asynchronous and may arrive mid-walk:
  - FSM returns to IDLE.
  - All outputs go to 0.
  - No `done` pulse is issued for the aborted walk.

## Timing
- Cycle 0 = IDLE with `start`=1. SETUP occurs at cycle 1.
- Cell k (1-based) is read at cycle 2+(k-1)(L+1) and evaluated at cycle 1+k(L+1), where L=READ_LATENCY.
- If the walk ends at cell k, `done` is asserted at cycle 2+k(L+1).
- `busy` is asserted from cycle 1 through the `done` cycle. It is 0 in IDLE, so the earliest next `start` is the cycle after `done`.
- Throughput is one cell every L+1 cycles.

## Configuration
- Macro: `BRESENHAM_RAYCAST_SKIP_ORIGIN_EN`.
- Defined:
  - The start cell is not read; SETUP performs one step before entering READ.
  - If the start cell equals the end cell, SETUP goes directly to DONE with hit=0, cell_count=0, hit_x/hit_y = start cell.
  - `done` then occurs at cycle 2.
- Undefined: the start cell is read first, as described in Operation.

## Test plan
All scenarios use L=1 and the macro undefined unless stated.
- Empty map, (2,5)→(6,5):
  - Reads at x=2..6, y=5.
  - `done` at cycle 12; hit=0, cell_count=5, hit=(6,5).
- Same ray with (4,5) occupied: hit=1, hit=(4,5), cell_count=3, `done` at cycle 8, no read issued for x=5.
- Diagonal (0,0)→(3,2), empty map:
  - Read sequence (0,0),(1,1),(2,1),(3,2).
  - Negative ray (5,5)→(5,2) reads y=5,4,3,2.
- L=3, (0,0)→(1,0), empty map:
  - `read_enable` at cycles 2 and 6; `done` at cycle 10.
  - `start` pulsed at cycle 4 is ignored.
- Macro defined, (3,3)→(3,3): `done` at cycle 2, cell_count=0, no `read_enable`.
- Reset low at cycle 5 of the first scenario:
  - All outputs 0 immediately; no `done` pulse.
  - A new `start` after reset release runs the full walk correctly.
